gate_sweep_ctrl: RTL

- Sequencer that exhaustively exercises a combinational N-input gate (xor/and/or/nor family) in hardware.
- Drives every input combination onto the gate, waits a settle window, samples the gate output, builds the observed truth table and compares it against an expected table.
- Sits beside the gate under test as its stimulus/check controller; replaces hand-written per-vector stimulus with one start pulse.

---
 rtl/gate_sweep_if.sv | 25 ++
 rtl/gate_sweep_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/gate_sweep_if.sv
// Bundle between gate_sweep_ctrl and its host plus the gate under test.
// master = controller side, slave = host/gate side.
interface gate_sweep_if #(
    parameter int N_IN = 2
);
    logic                   start;
    logic                   abort;
    logic                   y_in;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN-1:0]        a_vec;
    logic [N_IN-1:0]        fail_idx;
    logic [(1<<N_IN)-1:0]   table_out;

    modport master (
        input  start, abort, y_in,
        output a_vec, busy, done, pass, fail_idx, table_out
    );

    modport slave (
        output start, abort, y_in,
        input  a_vec, busy, done, pass, fail_idx, table_out
    );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive truth-table sweeper for an N_IN-input combinational gate.
// Optional macro GATE_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatching sample.
module gate_sweep_ctrl #(
    parameter int                   N_IN   = 2,
    parameter int                   SETTLE = 4,
    parameter logic [(1<<N_IN)-1:0] EXPECT = 4'b0110
) (
    input  logic         clk,
    input  logic         rst,
    gate_sweep_if.master bus
);
    localparam int                  NV       = 1 << N_IN;
    localparam int                  CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]     V_LAST   = N_IN'(NV - 1);

    typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

    state_t            state_q, state_d;
    logic [N_IN-1:0]   v_q, v_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NV-1:0]     tbl_q, tbl_d;
    logic              pass_q, pass_d;
    logic [N_IN-1:0]   fidx_q, fidx_d;

    function automatic logic [N_IN-1:0] lowest_set(input logic [NV-1:0] m);
        lowest_set = '0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = N_IN'(i);
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            v_q     <= '0;
            cnt_q   <= '0;
            tbl_q   <= '0;
            pass_q  <= 1'b0;
            fidx_q  <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            tbl_q   <= tbl_d;
            pass_q  <= pass_d;
            fidx_q  <= fidx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        tbl_d   = tbl_q;
        pass_d  = pass_q;
        fidx_d  = fidx_q;
        unique case (state_q)
            IDLE: begin
                // abort beats a simultaneous start
                if (bus.start && !bus.abort) begin
                    state_d = APPLY;
                    v_d     = '0;
                    cnt_d   = '0;
                    tbl_d   = '0;
                    pass_d  = 1'b0;
                    fidx_d  = '0;
                end
            end
            APPLY: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    tbl_d[v_q] = bus.y_in;
                    cnt_d      = '0;
`ifdef GATE_SWEEP_STOP_ON_FAIL_EN
                    if (bus.y_in != EXPECT[v_q]) begin
                        state_d = DONE;
                        pass_d  = 1'b0;
                        fidx_d  = v_q;
                    end else
`endif
                    if (v_q == V_LAST) begin
                        state_d = DONE;
                        pass_d  = (tbl_d == EXPECT);
                        fidx_d  = lowest_set(tbl_d ^ EXPECT);
                    end else begin
                        v_d = v_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (bus.abort) pass_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Aborting during the DONE cycle swallows the done pulse.
    assign bus.a_vec     = (state_q == APPLY) ? v_q : '0;
    assign bus.busy      = (state_q == APPLY);
    assign bus.done      = (state_q == DONE) && !bus.abort;
    assign bus.pass      = pass_q;
    assign bus.fail_idx  = fidx_q;
    assign bus.table_out = tbl_q;
endmodule
